sodor5_verif: RTL and testbench
===============================

Name: sodor5_verif

Overview:
- Self-checking lockstep harness for a RISC-V Sodor-style 5-stage core running an RV32I load/store/ADDI subset.
- Contains two independent engines fed by one external instruction stream, one instruction per cycle:
  - a forwarding 5-stage pipeline (ID/EX/MEM/WB after the instruction register);
  - a single-cycle ISA reference model, time-aligned to the pipeline's WB stage.
- Each engine has its own 32x32 register file and 16-word data memory. Architectural effects are compared every cycle; divergence raises a sticky mismatch flag.

Parameters:
- NUM_REGS, 32, architectural register count (x0 hardwired zero).
- WORD_SIZE, 32, datapath width.
- DMEM_WORDS, 16, data memory words per engine; byte address is taken modulo 64.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- instr  input  32  instruction presented to both engines each cycle. 0x00000013 is NOP.
- commit_valid  output  1  pipeline WB writes a register with rd != 0.
- commit_rd  output  5  WB destination register.
- commit_data  output  32  WB write data.
- store_valid  output  1  store event from the pipeline, retimed to WB.
- store_addr  output  6  store byte address.
- store_data  output  32  full memory word after the store merge.
- mismatch  output  1  sticky flag: pipeline and model have diverged.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - all pipeline stage registers become bubbles (NOP);
  - both register files clear to 0;
  - both dmems initialise to mem[i] = i * 0x11111111 (i = 0..15);
  - model delay line clears to NOP;
  - mismatch = 0 and all outputs = 0.
- Decode, identical in both engines:
  - opcode 0010011 with funct3 000: ADDI.
  - opcode 0000011: loads. funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - opcode 0100011: stores. funct3 000 SB, 001 SH, 010 SW.
  - Every other encoding is a NOP, including custom-0 (0001011) and undefined funct3 values.
- Immediates:
  - I-type: sign-extended instr[31:20].
  - S-type: sign-extended {instr[31:25], instr[11:7]}.
- Address = rs1 + imm, then modulo 64. Word index = addr[5:2].
  - Byte ops use addr[1:0] as the lane.
  - Half ops use addr[1]; addr[0] is ignored.
  - Word ops ignore addr[1:0].
- Loads sign-extend (LB/LH) or zero-extend (LBU/LHU). Writes to rd = 0 are discarded. x0 always reads 0.
- Pipeline timing, for an instruction sampled at edge k:
  - ID during cycle k+1: register file read, with write-through from the WB write of the same cycle.
  - EX during k+2: ALU/address; operands forwarded from MEM first, then WB.
  - MEM during k+3: dmem read is combinational; the store is written at the end of k+3. A MEM-stage load result is forwarded combinationally into EX, so there is never a stall.
  - WB during k+4: commit_* outputs are driven combinationally from the WB register; the register file is written at the end of k+4.
- The forwarding priority MEM > WB applies to both rs1 and rs2, including store data.
- Model:
  - instr passes through a 4-deep delay line; the model executes it combinationally in cycle k+4 and updates its state at the end of k+4.
  - Each cycle the model produces an expected register write (valid, rd, data) and an expected store (valid, addr, merged word).
  - The pipeline's store event is registered once so that it also appears in k+4.
- Checker:
  - mismatch sets on the edge after any inequality between the pipeline and model on writeback valid/rd/data or store valid/addr/word.
  - It remains set until reset.
- Throughput is one instruction per cycle, with no back-pressure.

Test Plan:
- Single ADDI: reset, then ADDI x2,x0,13 (0x00D00113) followed by NOPs -> 4 cycles later commit_valid=1, rd=2, data=0x0000000D; mismatch=0.
- Back-to-back dependency: 0x00D00113 then 0x31010113 -> second commit x2=0x0000031D, the result of forwarding from MEM.
- Byte loads: LB x3,7(x0) -> x3=0x00000011. LB at addr 0x20 -> 0xFFFFFF88. LBU at addr 0x20 -> 0x00000088.
- Load-use then store:
  - LW x3,8(x0), then SB x3,18(x0) -> store_valid=1, addr=0x12, store_data=0x44224444.
  - A subsequent LW of addr 16 returns 0x44224444.
- Ignored writes:
  - ADDI x0,x2,0x6A -> commit_valid=0 and x0 stays 0.
  - custom-0 0x0000000B -> no commit, no store.
- Random stream and reset:
  - 10k random mixed ADDI/load/store/junk words -> mismatch never asserts.
  - Asserting reset_n mid-stream clears outputs immediately and restores the dmem pattern.

Source files
------------

// File: rtl/sodor5_verif.sv
// Lockstep harness: a forwarding 5-stage RV32I (ADDI/load/store) pipeline and
// a single-cycle ISA model aligned to its WB stage. Both engines see the same
// instruction stream. Any divergence in register write-back or store events
// sets a sticky mismatch flag.
module sodor5_verif #(
  parameter int NUM_REGS   = 32,
  parameter int WORD_SIZE  = 32,
  parameter int DMEM_WORDS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] instr,
  output logic                 commit_valid,
  output logic [4:0]           commit_rd,
  output logic [WORD_SIZE-1:0] commit_data,
  output logic                 store_valid,
  output logic [5:0]           store_addr,
  output logic [WORD_SIZE-1:0] store_data,
  output logic                 mismatch
);

  typedef enum logic [1:0] {OP_NOP, OP_ADDI, OP_LD, OP_ST} op_e;
  localparam logic [WORD_SIZE-1:0] NOP = 32'h0000_0013;

  // Anything outside the supported subset, including bad funct3, is a NOP.
  function automatic op_e dec_op(input logic [31:0] i);
    dec_op = OP_NOP;
    case (i[6:0])
      7'b0010011: if (i[14:12] == 3'b000) dec_op = OP_ADDI;
      7'b0000011: if (i[14:12] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) dec_op = OP_LD;
      7'b0100011: if (i[14:12] inside {3'b000, 3'b001, 3'b010}) dec_op = OP_ST;
      default: ;
    endcase
  endfunction

  // Stores use the split S-type immediate; everything else is I-type.
  function automatic logic [31:0] imm_of(input logic [31:0] i);
    if (i[6:0] == 7'b0100011) imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
    else                      imm_of = {{20{i[31]}}, i[31:20]};
  endfunction

  // Lane extraction with sign or zero extension; halves ignore addr[0].
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lane, 3'b000});
    h = 16'(w >> {lane[1], 4'b0000});
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Merge store data into the existing word; the result is the whole new word.
  function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] data,
                                           input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] mask;
    logic [4:0]  sh;
    case (f3)
      3'b000:  begin sh = {lane, 3'b000};     mask = 32'h0000_00FF << sh; end
      3'b001:  begin sh = {lane[1], 4'b0000}; mask = 32'h0000_FFFF << sh; end
      default: begin sh = 5'd0;               mask = 32'hFFFF_FFFF;       end
    endcase
    st_merge = (old & ~mask) | ((data << sh) & mask);
  endfunction

  logic [WORD_SIZE-1:0] rf   [NUM_REGS];
  logic [WORD_SIZE-1:0] dmem [DMEM_WORDS];

  logic [31:0] ir_p1;
  op_e         ex_op_p2, mem_op_p3;
  logic [4:0]  ex_rd_p2, ex_rs1_p2, ex_rs2_p2, mem_rd_p3, wb_rd_p4;
  logic [2:0]  ex_f3_p2, mem_f3_p3;
  logic [31:0] ex_v1_p2, ex_v2_p2, ex_imm_p2, mem_alu_p3, mem_sd_p3, wb_data_p4;
  logic        wb_we_p4, st_vld_p4;
  logic [5:0]  st_addr_p4;
  logic [31:0] st_word_p4;

  // ---- ID: decode and register read with WB write-through ----
  op_e         id_op;
  logic [4:0]  id_rs1, id_rs2;
  logic [31:0] id_v1, id_v2;
  assign id_op  = dec_op(ir_p1);
  assign id_rs1 = ir_p1[19:15];
  assign id_rs2 = ir_p1[24:20];

  // Register read; a same-cycle WB write to the source wins over the array.
  always_comb begin
    id_v1 = rf[id_rs1];
    id_v2 = rf[id_rs2];
    if (wb_we_p4 && wb_rd_p4 == id_rs1) id_v1 = wb_data_p4;
    if (wb_we_p4 && wb_rd_p4 == id_rs2) id_v2 = wb_data_p4;
    if (id_rs1 == 5'd0) id_v1 = '0;
    if (id_rs2 == 5'd0) id_v2 = '0;
  end

  // ---- EX: operand forwarding (MEM over WB) and address/ADDI adder ----
  logic        mem_fwd;
  logic [31:0] mem_res, mem_ld, ex_a, ex_b, ex_alu;
  assign mem_fwd = (mem_op_p3 == OP_ADDI || mem_op_p3 == OP_LD) && mem_rd_p3 != 5'd0;
  assign mem_res = (mem_op_p3 == OP_LD) ? mem_ld : mem_alu_p3;

  // Forwarding mux; later assignments carry the higher priority.
  always_comb begin
    ex_a = ex_v1_p2;
    ex_b = ex_v2_p2;
    if (wb_we_p4 && wb_rd_p4 == ex_rs1_p2) ex_a = wb_data_p4;
    if (wb_we_p4 && wb_rd_p4 == ex_rs2_p2) ex_b = wb_data_p4;
    if (mem_fwd && mem_rd_p3 == ex_rs1_p2) ex_a = mem_res;
    if (mem_fwd && mem_rd_p3 == ex_rs2_p2) ex_b = mem_res;
  end
  assign ex_alu = ex_a + ex_imm_p2;

  // ---- MEM: combinational dmem read, load extract and store merge ----
  logic [5:0]  mem_addr;
  logic [31:0] mem_word, mem_st_word;
  assign mem_addr    = mem_alu_p3[5:0];
  assign mem_word    = dmem[mem_addr[5:2]];
  assign mem_ld      = load_ext(mem_word, mem_f3_p3, mem_addr[1:0]);
  assign mem_st_word = st_merge(mem_word, mem_sd_p3, mem_f3_p3, mem_addr[1:0]);

  // Pipeline stage registers; reset fills every stage with a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_p1 <= NOP;
      ex_op_p2 <= OP_NOP; ex_rd_p2 <= '0; ex_rs1_p2 <= '0; ex_rs2_p2 <= '0; ex_f3_p2 <= '0;
      ex_v1_p2 <= '0; ex_v2_p2 <= '0; ex_imm_p2 <= '0;
      mem_op_p3 <= OP_NOP; mem_rd_p3 <= '0; mem_f3_p3 <= '0; mem_alu_p3 <= '0; mem_sd_p3 <= '0;
      wb_we_p4 <= 1'b0; wb_rd_p4 <= '0; wb_data_p4 <= '0;
      st_vld_p4 <= 1'b0; st_addr_p4 <= '0; st_word_p4 <= '0;
    end else begin
      ir_p1 <= instr;
      ex_op_p2 <= id_op; ex_rd_p2 <= ir_p1[11:7]; ex_rs1_p2 <= id_rs1; ex_rs2_p2 <= id_rs2;
      ex_f3_p2 <= ir_p1[14:12]; ex_v1_p2 <= id_v1; ex_v2_p2 <= id_v2; ex_imm_p2 <= imm_of(ir_p1);
      mem_op_p3 <= ex_op_p2; mem_rd_p3 <= ex_rd_p2; mem_f3_p3 <= ex_f3_p2;
      mem_alu_p3 <= ex_alu; mem_sd_p3 <= ex_b;
      wb_we_p4   <= mem_fwd;
      wb_rd_p4   <= mem_fwd ? mem_rd_p3 : 5'd0;
      wb_data_p4 <= mem_fwd ? mem_res : 32'd0;
      st_vld_p4  <= (mem_op_p3 == OP_ST);
      st_addr_p4 <= (mem_op_p3 == OP_ST) ? mem_addr : 6'd0;
      st_word_p4 <= (mem_op_p3 == OP_ST) ? mem_st_word : 32'd0;
    end
  end

  // ---- WB: commit outputs straight from the WB register ----
  assign commit_valid = wb_we_p4;
  assign commit_rd    = wb_rd_p4;
  assign commit_data  = wb_data_p4;
  assign store_valid  = st_vld_p4;
  assign store_addr   = st_addr_p4;
  assign store_data   = st_word_p4;

  // Pipeline register file write at the end of WB; x0 never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
    else if (wb_we_p4) rf[wb_rd_p4] <= wb_data_p4;
  end

  // Pipeline dmem: word i resets to i repeated in every nibble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) for (int w = 0; w < DMEM_WORDS; w++) dmem[w] <= {8{w[3:0]}};
    else if (mem_op_p3 == OP_ST) dmem[mem_addr[5:2]] <= mem_st_word;
  end

  // ---- Reference model: 4-deep delay, executes in the WB cycle ----
  logic [31:0] m_dl   [4];
  logic [31:0] m_rf   [NUM_REGS];
  logic [31:0] m_dmem [DMEM_WORDS];
  logic [31:0] m_i, m_a, m_b, m_sum, m_word;
  op_e         m_op;
  logic        exp_we, exp_st;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data, exp_sword;
  logic [5:0]  exp_saddr;

  assign m_i    = m_dl[3];
  assign m_op   = dec_op(m_i);
  assign m_a    = (m_i[19:15] == 5'd0) ? 32'd0 : m_rf[m_i[19:15]];
  assign m_b    = (m_i[24:20] == 5'd0) ? 32'd0 : m_rf[m_i[24:20]];
  assign m_sum  = m_a + imm_of(m_i);
  assign m_word = m_dmem[m_sum[5:2]];

  // Architectural effect of the model instruction in this cycle.
  always_comb begin
    exp_we    = (m_op == OP_ADDI || m_op == OP_LD) && m_i[11:7] != 5'd0;
    exp_rd    = exp_we ? m_i[11:7] : 5'd0;
    exp_data  = 32'd0;
    if (exp_we) exp_data = (m_op == OP_LD) ? load_ext(m_word, m_i[14:12], m_sum[1:0]) : m_sum;
    exp_st    = (m_op == OP_ST);
    exp_saddr = exp_st ? m_sum[5:0] : 6'd0;
    exp_sword = exp_st ? st_merge(m_word, m_b, m_i[14:12], m_sum[1:0]) : 32'd0;
  end

  // Model state: delay line, register file and dmem.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 4; d++) m_dl[d] <= NOP;
      for (int r = 0; r < NUM_REGS; r++) m_rf[r] <= '0;
      for (int w = 0; w < DMEM_WORDS; w++) m_dmem[w] <= {8{w[3:0]}};
    end else begin
      m_dl[0] <= instr;
      for (int d = 1; d < 4; d++) m_dl[d] <= m_dl[d-1];
      if (exp_we) m_rf[exp_rd] <= exp_data;
      if (exp_st) m_dmem[exp_saddr[5:2]] <= exp_sword;
    end
  end

  // Sticky divergence flag; inactive fields are zero in both engines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mismatch <= 1'b0;
    else if ({commit_valid, commit_rd, commit_data} != {exp_we, exp_rd, exp_data} ||
             {store_valid, store_addr, store_data} != {exp_st, exp_saddr, exp_sword})
      mismatch <= 1'b1;
  end

endmodule

// File: tb/tb_sodor5_verif.sv
// Bench for sodor5_verif: directed scenarios plus a random instruction stream,
// checked by a scoreboard fed from a byte-addressed architectural model.
module tb_sodor5_verif;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr = 32'h0000_0013;
  logic        commit_valid, store_valid, mismatch;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data, store_data;
  logic [5:0]  store_addr;

  sodor5_verif dut (
    .clk(clk), .reset_n(reset_n), .instr(instr),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
    .store_valid(store_valid), .store_addr(store_addr), .store_data(store_data),
    .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [4:0] rd; logic [31:0] data; } cexp_t;
  typedef struct { int due; logic [5:0] addr; logic [31:0] word; } sexp_t;

  cexp_t cq[$];
  sexp_t sq[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_commit = 0, n_store = 0, last_commit_cyc = 0, last_edge = 0;
  logic [4:0]  last_rd;
  logic [31:0] last_data, last_sdata;
  logic [5:0]  last_saddr;

  logic [31:0] regs [32];
  logic [7:0]  mb   [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] mword(input int base);
    return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) regs[r] = '0;
    for (int w = 0; w < 16; w++)
      for (int b = 0; b < 4; b++) mb[4*w+b] = 8'(w * 17);
  endtask

  // Architectural execution in program order; expected events carry the
  // observation cycle at which they must appear.
  task automatic model_exec(input logic [31:0] x, input int due);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] s1, s2, imm_i, imm_s, v, sum;
    int a, hb, wb;
    cexp_t ce;
    sexp_t se;
    opc = x[6:0]; f3 = x[14:12]; rd = x[11:7]; rs1 = x[19:15]; rs2 = x[24:20];
    s1 = (rs1 == 0) ? 32'd0 : regs[rs1];
    s2 = (rs2 == 0) ? 32'd0 : regs[rs2];
    imm_i = {{20{x[31]}}, x[31:20]};
    imm_s = {{20{x[31]}}, x[31:25], x[11:7]};
    if (opc == 7'h13 && f3 == 3'd0) begin
      v = s1 + imm_i;
      if (rd != 0) begin
        regs[rd] = v;
        ce.due = due; ce.rd = rd; ce.data = v; cq.push_back(ce);
      end
    end else if (opc == 7'h03 && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) begin
      sum = s1 + imm_i;
      a = int'(sum % 64); hb = a - a % 2; wb = a - a % 4;
      case (f3)
        3'd0:    v = {{24{mb[a][7]}}, mb[a]};
        3'd4:    v = {24'd0, mb[a]};
        3'd1:    v = {{16{mb[hb+1][7]}}, mb[hb+1], mb[hb]};
        3'd5:    v = {16'd0, mb[hb+1], mb[hb]};
        default: v = mword(wb);
      endcase
      if (rd != 0) begin
        regs[rd] = v;
        ce.due = due; ce.rd = rd; ce.data = v; cq.push_back(ce);
      end
    end else if (opc == 7'h23 && f3 <= 3'd2) begin
      sum = s1 + imm_s;
      a = int'(sum % 64); hb = a - a % 2; wb = a - a % 4;
      case (f3)
        3'd0: mb[a] = s2[7:0];
        3'd1: begin mb[hb] = s2[7:0]; mb[hb+1] = s2[15:8]; end
        default: begin
          mb[wb] = s2[7:0]; mb[wb+1] = s2[15:8]; mb[wb+2] = s2[23:16]; mb[wb+3] = s2[31:24];
        end
      endcase
      se.due = due; se.addr = 6'(a); se.word = mword(wb); sq.push_back(se);
    end
  endtask

  task automatic issue(input logic [31:0] x);
    @(negedge clk);
    instr = x;
    last_edge = cyc + 1;
    model_exec(x, cyc + 4);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(32'h0000_0013);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    instr = 32'h0000_0013;
    #1;
    check("rst_commit_valid", 32'(commit_valid), 0);
    check("rst_commit_rd", 32'(commit_rd), 0);
    check("rst_commit_data", commit_data, 0);
    check("rst_store_valid", 32'(store_valid), 0);
    check("rst_store_addr", 32'(store_addr), 0);
    check("rst_store_data", store_data, 0);
    check("rst_mismatch", 32'(mismatch), 0);
    cq.delete();
    sq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // Monitor: consumes expected events whenever the DUT presents an output.
  always @(negedge clk) begin
    if (reset_n) begin
      if (commit_valid) begin
        if (cq.size() == 0) check("commit_unexpected", 32'(commit_valid), 0);
        else begin
          cexp_t c;
          c = cq.pop_front();
          check("commit_cycle", 32'(cyc), 32'(c.due));
          check("commit_rd", 32'(commit_rd), 32'(c.rd));
          check("commit_data", commit_data, c.data);
          n_commit++; last_rd = commit_rd; last_data = commit_data; last_commit_cyc = cyc;
        end
      end else if (cq.size() != 0 && cq[0].due <= cyc) begin
        check("commit_missing", 32'(commit_valid), 1);
        void'(cq.pop_front());
      end
      if (store_valid) begin
        if (sq.size() == 0) check("store_unexpected", 32'(store_valid), 0);
        else begin
          sexp_t s;
          s = sq.pop_front();
          check("store_cycle", 32'(cyc), 32'(s.due));
          check("store_addr", 32'(store_addr), 32'(s.addr));
          check("store_data", store_data, s.word);
          n_store++; last_saddr = store_addr; last_sdata = store_data;
        end
      end else if (sq.size() != 0 && sq[0].due <= cyc) begin
        check("store_missing", 32'(store_valid), 1);
        void'(sq.pop_front());
      end
      check("mismatch_flag", 32'(mismatch), 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, c0, s0, r;
    logic [31:0] x;
    model_reset();
    do_reset();

    // Single ADDI and its latency
    issue(32'h00D0_0113); e = last_edge;
    nops(6);
    check("addi_rd", 32'(last_rd), 2);
    check("addi_data", last_data, 32'h0000_000D);
    check("addi_latency", 32'(last_commit_cyc), 32'(e + 3));

    // Back-to-back dependency through MEM forwarding
    issue(32'h00D0_0113);
    issue(32'h3101_0113);
    nops(6);
    check("fwd_mem_data", last_data, 32'h0000_031D);

    // Byte loads
    issue(enc_i(7'h03, 3'd0, 5'd3, 5'd0, 12'd7));  nops(5);
    check("lb_7", last_data, 32'h0000_0011);
    issue(enc_i(7'h03, 3'd0, 5'd4, 5'd0, 12'h20)); nops(5);
    check("lb_20", last_data, 32'hFFFF_FF88);
    issue(enc_i(7'h03, 3'd4, 5'd5, 5'd0, 12'h20)); nops(5);
    check("lbu_20", last_data, 32'h0000_0088);

    // Load-use into store data, then read back
    issue(enc_i(7'h03, 3'd2, 5'd3, 5'd0, 12'd8));
    issue(enc_s(3'd0, 5'd0, 5'd3, 12'd18));
    nops(5);
    check("sb_addr", 32'(last_saddr), 32'h12);
    check("sb_word", last_sdata, 32'h4422_4444);
    issue(enc_i(7'h03, 3'd2, 5'd6, 5'd0, 12'd16)); nops(5);
    check("lw_after_sb", last_data, 32'h4422_4444);

    // Ignored writes: rd=x0 and custom-0
    c0 = n_commit; s0 = n_store;
    issue(enc_i(7'h13, 3'd0, 5'd0, 5'd2, 12'h06A));
    issue(32'h0000_000B);
    nops(6);
    check("x0_no_commit", 32'(n_commit), 32'(c0));
    check("custom_no_store", 32'(n_store), 32'(s0));
    issue(enc_i(7'h13, 3'd0, 5'd7, 5'd0, 12'd0)); nops(5);
    check("x0_reads_zero", last_data, 32'd0);

    // Random mixed stream with a mid-stream reset
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        do_reset();
        issue(enc_i(7'h03, 3'd2, 5'd1, 5'd0, 12'd16)); nops(5);
        check("reset_dmem_restored", last_data, 32'h4444_4444);
        issue(enc_i(7'h13, 3'd0, 5'd2, 5'd2, 12'd0)); nops(5);
        check("reset_rf_cleared", last_data, 32'd0);
      end
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: x = enc_i(7'h13, 3'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           12'($urandom));
        3, 4, 5: begin
          case ($urandom_range(0, 4))
            0: x = enc_i(7'h03, 3'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom));
            1: x = enc_i(7'h03, 3'd1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom));
            2: x = enc_i(7'h03, 3'd2, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom));
            3: x = enc_i(7'h03, 3'd4, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom));
            default: x = enc_i(7'h03, 3'd5, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom));
          endcase
        end
        6, 7: x = enc_s(3'($urandom_range(0, 2)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 12'($urandom));
        8: x = $urandom;
        default: begin
          x = $urandom;
          case ($urandom_range(0, 3))
            0: x[6:0] = 7'b0001011;
            1: begin x[6:0] = 7'b0000011; x[14:12] = 3'($urandom_range(6, 7)); end
            2: begin x[6:0] = 7'b0100011; x[14:12] = 3'($urandom_range(3, 7)); end
            default: begin x[6:0] = 7'b0010011; x[14:12] = 3'($urandom_range(1, 7)); end
          endcase
        end
      endcase
      issue(x);
    end
    nops(8);
    check("commit_queue_drained", 32'(cq.size()), 0);
    check("store_queue_drained", 32'(sq.size()), 0);
    check("final_mismatch", 32'(mismatch), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
